v30mz_bus_responder: RTL and testbench

V30MZ_BUS_RESPONDER -- requirements
Module: v30mz_bus_responder

---
 rtl/v30mz_bus_responder.sv | 108 ++++++++++
 tb/tb_v30mz_bus_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/v30mz_bus_responder.sv
// Memory-bus slave for a V30MZ-style CPU: latches one read/write cycle, optionally inserts wait
// states, performs a single SRAM access and returns an active-low ready strobe.
module v30mz_bus_responder #(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  bus_status,
    input  logic [19:0] address_in,
    input  logic        bus_upper_byte_enable,
    input  logic [15:0] cpu_data_in,
    output logic [15:0] cpu_data_out,
    output logic        readyb,
    output logic        bus_error,
    output logic        sram_en,
    output logic        sram_we,
    output logic [18:0] sram_addr,
    output logic [1:0]  sram_be,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata
);

    localparam logic [3:0] StatusRead  = 4'b1001;
    localparam logic [3:0] StatusWrite = 4'b1010;
    localparam logic [3:0] WaitLoad    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAccess,
        StResp
    } state_t;

    state_t     state;
    logic [3:0] wait_cnt;
    logic       lat_write;

    logic       req_valid;
    logic       req_write;
    logic [1:0] req_be;

    assign req_write = (bus_status == StatusWrite);
    assign req_valid = (bus_status == StatusRead) || req_write;
    assign req_be    = {bus_upper_byte_enable, ~address_in[0]};

    // Read data passes straight through during RESP, when the SRAM has it on sram_rdata.
    assign cpu_data_out = (state == StResp && !lat_write) ? sram_rdata : 16'h0000;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            wait_cnt   <= 4'd0;
            lat_write  <= 1'b0;
            sram_addr  <= 19'd0;
            sram_be    <= 2'b00;
            sram_wdata <= 16'h0000;
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            readyb     <= 1'b1;
            bus_error  <= 1'b0;
        end else begin
            sram_en   <= 1'b0;
            sram_we   <= 1'b0;
            readyb    <= 1'b1;
            bus_error <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        lat_write  <= req_write;
                        sram_addr  <= address_in[19:1];
                        sram_be    <= req_be;
                        sram_wdata <= cpu_data_in;
                        if (WAIT_STATES > 0) begin
                            state    <= StWait;
                            wait_cnt <= WaitLoad;
                        end else begin
                            state   <= StAccess;
                            sram_en <= (req_be != 2'b00);
                            sram_we <= req_write && (req_be != 2'b00);
                        end
                    end
                end
                StWait: begin
                    if (wait_cnt == 4'd0) begin
                        state   <= StAccess;
                        sram_en <= (sram_be != 2'b00);
                        sram_we <= lat_write && (sram_be != 2'b00);
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                StAccess: begin
                    // An access with no lane enabled still completes, but flags an error.
                    state     <= StResp;
                    readyb    <= 1'b0;
                    bus_error <= (sram_be == 2'b00);
                end
                StResp: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_v30mz_bus_responder.sv
// Scoreboard bench for v30mz_bus_responder: three instances (0, 3 and 5 wait states) share the
// CPU-side stimulus; expected SRAM strobes and responses are queued at issue time.
module tb_v30mz_bus_responder;

    typedef struct {
        int          cyc;
        logic [18:0] addr;
        logic [1:0]  be;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } sram_exp_t;

    typedef struct {
        int          cyc;
        logic        chk_data;
        logic [15:0] data;
        logic        err;
    } resp_exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  bus_status = 4'h0;
    logic [19:0] address_in = 20'h0;
    logic        bus_upper_byte_enable = 1'b0;
    logic [15:0] cpu_data_in = 16'h0;
    logic [15:0] sram_rdata = 16'h5A5A;

    logic [15:0] dout_v [3];
    logic [2:0]  readyb_v;
    logic [2:0]  err_v;
    logic [2:0]  en_v;
    logic [2:0]  we_v;
    logic [18:0] addr_v [3];
    logic [1:0]  be_v [3];
    logic [15:0] wdata_v [3];

    logic [1:0]  sel = 2'd0;
    logic [15:0] dout_m;
    logic        rb_m, err_m, en_m, we_m;
    logic [18:0] addr_m;
    logic [1:0]  be_m;
    logic [15:0] wdata_m;

    assign dout_m  = dout_v[sel];
    assign rb_m    = readyb_v[sel];
    assign err_m   = err_v[sel];
    assign en_m    = en_v[sel];
    assign we_m    = we_v[sel];
    assign addr_m  = addr_v[sel];
    assign be_m    = be_v[sel];
    assign wdata_m = wdata_v[sel];

    v30mz_bus_responder #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .bus_status(bus_status), .address_in(address_in),
        .bus_upper_byte_enable(bus_upper_byte_enable), .cpu_data_in(cpu_data_in),
        .cpu_data_out(dout_v[0]), .readyb(readyb_v[0]), .bus_error(err_v[0]),
        .sram_en(en_v[0]), .sram_we(we_v[0]), .sram_addr(addr_v[0]), .sram_be(be_v[0]),
        .sram_wdata(wdata_v[0]), .sram_rdata(sram_rdata)
    );

    v30mz_bus_responder #(.WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset), .bus_status(bus_status), .address_in(address_in),
        .bus_upper_byte_enable(bus_upper_byte_enable), .cpu_data_in(cpu_data_in),
        .cpu_data_out(dout_v[1]), .readyb(readyb_v[1]), .bus_error(err_v[1]),
        .sram_en(en_v[1]), .sram_we(we_v[1]), .sram_addr(addr_v[1]), .sram_be(be_v[1]),
        .sram_wdata(wdata_v[1]), .sram_rdata(sram_rdata)
    );

    v30mz_bus_responder #(.WAIT_STATES(5)) dut5 (
        .clk(clk), .reset(reset), .bus_status(bus_status), .address_in(address_in),
        .bus_upper_byte_enable(bus_upper_byte_enable), .cpu_data_in(cpu_data_in),
        .cpu_data_out(dout_v[2]), .readyb(readyb_v[2]), .bus_error(err_v[2]),
        .sram_en(en_v[2]), .sram_we(we_v[2]), .sram_addr(addr_v[2]), .sram_be(be_v[2]),
        .sram_wdata(wdata_v[2]), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int n_en = 0;
    int n_rdy = 0;
    sram_exp_t sram_q[$];
    resp_exp_t resp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: sample mid-cycle, model the SRAM read port one cycle after a read strobe.
    logic [15:0] rdata_pending = 16'h0;
    always @(negedge clk) begin
        sram_exp_t se;
        resp_exp_t re;
        if (en_m === 1'b1) begin
            n_en++;
            if (sram_q.size() == 0) begin
                check("spurious_sram_en", 32'd1, 32'd0);
            end else begin
                se = sram_q.pop_front();
                check("sram_en_cycle", cyc, se.cyc);
                check("sram_addr", {13'd0, addr_m}, {13'd0, se.addr});
                check("sram_be", {30'd0, be_m}, {30'd0, se.be});
                check("sram_we", {31'd0, we_m}, {31'd0, se.we});
                if (se.we) check("sram_wdata", {16'd0, wdata_m}, {16'd0, se.wdata});
                check("dout_in_access", {16'd0, dout_m}, 32'd0);
                rdata_pending = se.rdata;
            end
        end
        if (rb_m === 1'b0) begin
            n_rdy++;
            if (resp_q.size() == 0) begin
                check("spurious_readyb", 32'd1, 32'd0);
            end else begin
                re = resp_q.pop_front();
                check("readyb_cycle", cyc, re.cyc);
                check("bus_error", {31'd0, err_m}, {31'd0, re.err});
                if (re.chk_data) check("cpu_data_out", {16'd0, dout_m}, {16'd0, re.data});
            end
        end else if (err_m === 1'b1) begin
            check("stray_bus_error", 32'd1, 32'd0);
        end
        sram_rdata = (en_m === 1'b1 && we_m !== 1'b1) ? rdata_pending : 16'h5A5A;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one request now; the current cycle is the sampling IDLE cycle (cycle 0).
    task automatic issue(input logic wr, input logic [19:0] a, input logic ube,
                         input logic [15:0] wd, input logic [15:0] rd, input int ws);
        logic [1:0] be;
        be = {ube, ~a[0]};
        bus_status = wr ? 4'b1010 : 4'b1001;
        address_in = a;
        bus_upper_byte_enable = ube;
        cpu_data_in = wd;
        if (be != 2'b00) sram_q.push_back('{cyc + 1 + ws, a[19:1], be, wr, wd, rd});
        resp_q.push_back('{cyc + 2 + ws, !wr && be != 2'b00, rd, be == 2'b00});
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (sram_q.size() != 0 || resp_q.size() != 0); i++) step(1);
        if (sram_q.size() != 0 || resp_q.size() != 0) begin
            check("drain_timeout", sram_q.size() + resp_q.size(), 32'd0);
            sram_q.delete();
            resp_q.delete();
        end
        step(3);
    endtask

    int en0, rdy0;

    initial begin
        step(3);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_readyb", {31'd0, readyb_v[i]}, 32'd1);
            check("rst_bus_error", {31'd0, err_v[i]}, 32'd0);
            check("rst_sram_en", {31'd0, en_v[i]}, 32'd0);
            check("rst_sram_we", {31'd0, we_v[i]}, 32'd0);
            check("rst_dout", {16'd0, dout_v[i]}, 32'd0);
            check("rst_sram_addr", {13'd0, addr_v[i]}, 32'd0);
            check("rst_sram_be", {30'd0, be_v[i]}, 32'd0);
            check("rst_sram_wdata", {16'd0, wdata_v[i]}, 32'd0);
        end

        // Read straight after reset release, 0 wait states.
        sel = 2'd0;
        issue(1'b0, 20'hFFFF0, 1'b1, 16'h0000, 16'hEAEA, 0);
        step(1);
        bus_status = 4'h0;
        drain();

        // Even-address write with only the low lane.
        issue(1'b1, 20'h2468A, 1'b0, 16'hBEEF, 16'h0000, 0);
        step(1);
        bus_status = 4'h0;
        drain();

        // No lane enabled: error response, no SRAM strobe.
        en0 = n_en;
        issue(1'b0, 20'h00003, 1'b0, 16'h0000, 16'h0000, 0);
        step(1);
        bus_status = 4'h0;
        drain();
        check("no_lane_no_sram_en", n_en - en0, 32'd0);

        // Back-to-back reads, status held, address moved on the readyb cycle.
        en0 = n_en;
        rdy0 = n_rdy;
        issue(1'b0, 20'h12344, 1'b1, 16'h0000, 16'h1111, 0);
        step(2);
        address_in = 20'h54321;
        step(1);
        issue(1'b0, 20'h54321, 1'b1, 16'h0000, 16'h2222, 0);
        step(1);
        bus_status = 4'h0;
        drain();
        check("b2b_sram_en_count", n_en - en0, 32'd2);
        check("b2b_readyb_count", n_rdy - rdy0, 32'd2);

        // 3 wait states; status/address/data changes during WAIT must not leak in.
        sel = 2'd1;
        issue(1'b1, 20'h00101, 1'b1, 16'h1234, 16'h0000, 3);
        step(1);
        bus_status = 4'b1001;
        address_in = 20'hABCDE;
        cpu_data_in = 16'hFFFF;
        bus_upper_byte_enable = 1'b0;
        step(3);
        bus_status = 4'h0;
        drain();

        // Reset in WAIT aborts the cycle; a fresh read right after release completes.
        sel = 2'd2;
        en0 = n_en;
        rdy0 = n_rdy;
        bus_status = 4'b1001;
        address_in = 20'h00400;
        bus_upper_byte_enable = 1'b1;
        step(1);
        bus_status = 4'h0;
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        issue(1'b0, 20'h00402, 1'b1, 16'h0000, 16'hC0DE, 5);
        step(1);
        bus_status = 4'h0;
        drain();
        check("reset_abort_sram_en", n_en - en0, 32'd1);
        check("reset_abort_readyb", n_rdy - rdy0, 32'd1);

        // Non-memory cycle codes are ignored.
        sel = 2'd0;
        en0 = n_en;
        rdy0 = n_rdy;
        bus_status = 4'hF;
        step(10);
        bus_status = 4'b0001;
        step(10);
        bus_status = 4'h0;
        step(3);
        check("idle_codes_sram_en", n_en - en0, 32'd0);
        check("idle_codes_readyb", n_rdy - rdy0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
